alu_seq: RTL and testbench

- Sequenced front end for the 4-bit combinational `alu` (mode-encoded ops: m=0..7 arithmetic/logic, m=8..15 shift/rotate).
- Accepts operation requests over a valid/ready interface and registers the operands onto an internal `alu` instance.
- Waits a programmable settle time, then captures `r`/`overflow` and returns them over a second valid/ready interface.
- Keeps running op and overflow counters. It is the consuming end of the `alu` interface: the `alu` is the responder, this block is the initiator and result collector.

---
 rtl/alu_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_seq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequenced valid/ready front end for a 4-bit alu.
// Latches a request onto the alu, waits SETTLE cycles, returns r/ovf.
// Ports:
//   clk, rst              clock, async active-high reset
//   req_valid/req_ready   request handshake
//   req_a, req_b          operands
//   req_cin, req_m        carry-in, alu mode
//   rsp_valid/rsp_ready   response handshake
//   rsp_r, rsp_ovf        captured alu result / overflow
//   rsp_m                 mode echo of the op that produced rsp_r
//   op_count              results captured (wraps)
//   ovf_count             results with overflow (saturates)
module alu_seq #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_a,
  input  logic [3:0]       req_b,
  input  logic             req_cin,
  input  logic [3:0]       req_m,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_r,
  output logic             rsp_ovf,
  output logic [3:0]       rsp_m,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LOAD = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] opa;
  logic [3:0] opb;
  logic       opcin;
  logic [3:0] opm;
  logic [3:0] cnt;
  logic [3:0] alu_r;
  logic       alu_ovf;
  logic       accept;
  logic       hs;
  logic       done;

  assign accept = req_valid & req_ready;
  assign hs     = rsp_valid & rsp_ready;
  assign done   = (state == WAIT) && (cnt == 4'd0);

  alu u_alu (
    .a        (opa),
    .b        (opb),
    .cin      (opcin),
    .m        (opm),
    .r        (alu_r),
    .overflow (alu_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = WAIT;
      WAIT: if (cnt == 4'd0) state_nx = RESP;
      RESP: if (hs) state_nx = accept ? WAIT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // In RESP the slot frees up in the same cycle the result is taken.
  always_comb begin
    req_ready = 1'b0;
    unique case (state)
      IDLE:    req_ready = 1'b1;
      RESP:    req_ready = rsp_ready;
      default: req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa       <= '0;
      opb       <= '0;
      opcin     <= 1'b0;
      opm       <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
      rsp_ovf   <= 1'b0;
      rsp_m     <= '0;
      op_count  <= '0;
      ovf_count <= '0;
    end else begin
      if (accept) begin
        opa   <= req_a;
        opb   <= req_b;
        opcin <= req_cin;
        opm   <= req_m;
        cnt   <= LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (hs) rsp_valid <= 1'b0;
      // Capture and handshake never coincide: rsp_valid is low in WAIT.
      if (done) begin
        rsp_valid <= 1'b1;
        rsp_r     <= alu_r;
        rsp_ovf   <= alu_ovf;
        rsp_m     <= opm;
        op_count  <= op_count + 1'b1;
        if (alu_ovf && ovf_count != '1)
          ovf_count <= ovf_count + 1'b1;
      end
    end
  end

endmodule

// alu: 4-bit combinational alu.
// m 0..7 arith/logic, m 8..15 shift/rotate (overflow 0 for those).
module alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic [3:0] m,
  output logic [3:0] r,
  output logic       overflow
);

  logic [3:0] nb;
  assign nb = ~b;

  always_comb begin
    r        = '0;
    overflow = 1'b0;
    unique case (m)
      4'd0: begin
        r        = a + b + {3'b0, cin};
        overflow = (a[3] == b[3]) && (r[3] != a[3]);
      end
      4'd1: begin
        // a - b - !cin, as a + ~b + cin
        r        = a + nb + {3'b0, cin};
        overflow = (a[3] != b[3]) && (r[3] != a[3]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin
        r        = a + {3'b0, cin};
        overflow = !a[3] && r[3];
      end
      4'd7:  r = b;
      4'd8:  r = {a[2:0], 1'b0};
      4'd9:  r = {a[2:0], cin};
      4'd10: r = {1'b0, a[3:1]};
      4'd11: r = {cin, a[3:1]};
      4'd12: r = {a[3], a[3:1]};
      4'd13: r = {a[1:0], a[3:2]};
      4'd14: r = {a[2:0], a[3]};
      4'd15: r = {a[0], a[3:1]};
      default: r = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq.
// u0: SETTLE=1 CNT_W=8, u1: SETTLE=3 CNT_W=2.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_cin;
  logic [1:0][3:0] req_a;
  logic [1:0][3:0] req_b;
  logic [1:0][3:0] req_m;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [1:0]      rsp_ovf;
  logic [1:0][3:0] rsp_r;
  logic [1:0][3:0] rsp_m;
  logic [7:0]      opc0;
  logic [7:0]      ovc0;
  logic [1:0]      opc1;
  logic [1:0]      ovc1;

  alu_seq #(.SETTLE(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]),
    .req_cin(req_cin[0]), .req_m(req_m[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_r(rsp_r[0]), .rsp_ovf(rsp_ovf[0]), .rsp_m(rsp_m[0]),
    .op_count(opc0), .ovf_count(ovc0)
  );

  alu_seq #(.SETTLE(3), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]),
    .req_cin(req_cin[1]), .req_m(req_m[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_r(rsp_r[1]), .rsp_ovf(rsp_ovf[1]), .rsp_m(rsp_m[1]),
    .op_count(opc1), .ovf_count(ovc1)
  );

  typedef struct {
    int r;
    int ovf;
    int m;
    int opc;
    int ovc;
  } exp_t;

  exp_t sb[2][$];
  int   mopc[2];
  int   movc[2];
  int   cmax[2];
  int   rmode[2];
  int   hs_cyc[2];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int opcnt(input int d);
    return (d == 0) ? int'(opc0) : int'(opc1);
  endfunction

  function automatic int ovcnt(input int d);
    return (d == 0) ? int'(ovc0) : int'(ovc1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference alu from the mode table, plain integer arithmetic.
  function automatic void model(input int a, input int b,
                                input int cin, input int m,
                                output int r, output int ov);
    int sa, sb2, s;
    sa  = (a > 7) ? a - 16 : a;
    sb2 = (b > 7) ? b - 16 : b;
    s   = 0;
    ov  = 0;
    r   = 0;
    case (m)
      0: begin s = sa + sb2 + cin; r = (a + b + cin) % 16;
               ov = (s > 7 || s < -8); end
      1: begin s = sa - sb2 - 1 + cin; r = (a - b - 1 + cin + 32) % 16;
               ov = (s > 7 || s < -8); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin s = sa + cin; r = (a + cin) % 16; ov = (s > 7); end
      7: r = b;
      8: r = (a * 2) % 16;
      9: r = (a * 2 + cin) % 16;
      10: r = a / 2;
      11: r = a / 2 + 8 * cin;
      12: r = a / 2 + ((a >= 8) ? 8 : 0);
      13: r = (a % 4) * 4 + a / 4;
      14: r = (a * 2) % 16 + a / 8;
      default: r = a / 2 + (a % 2) * 8;
    endcase
  endfunction

  // Call off-edge; returns #1 after the accepting edge.
  task automatic issue(input int d, input int a, input int b,
                       input int cin, input int m, output int acc);
    int n;
    int r, ov;
    exp_t e;
    req_a[d]     = 4'(a);
    req_b[d]     = 4'(b);
    req_cin[d]   = 1'(cin);
    req_m[d]     = 4'(m);
    req_valid[d] = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!req_ready[d] && n < 100);
    acc = cyc;
    if (!req_ready[d]) begin
      chk("accept_timeout", 0, 1);
      acc = -1;
    end else begin
      model(a, b, cin, m, r, ov);
      mopc[d] = (mopc[d] + 1) % cmax[d];
      if (ov != 0 && movc[d] < cmax[d] - 1) movc[d]++;
      e.r = r; e.ovf = ov; e.m = m;
      e.opc = mopc[d]; e.ovc = movc[d];
      sb[d].push_back(e);
    end
    #1 req_valid[d] = 1'b0;
  endtask

  task automatic check_lat(input int d, input int s);
    for (int i = 1; i < s; i++) begin
      @(posedge clk);
      #1 chk("lat_early", rsp_valid[d], 0);
    end
    @(posedge clk);
    #1 chk("lat_valid", rsp_valid[d], 1);
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while ((sb[d].size() != 0 || rsp_valid[d]) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain", (n < 300) ? 1 : 0, 1);
  endtask

  task automatic rstream(input int d, input int cnt);
    int acc;
    for (int i = 0; i < cnt; i++) begin
      issue(d, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 15), acc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  // Consumer: drives rsp_ready per mode (0 hold, 1 ready, 2 random).
  always @(posedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      if (rmode[d] == 0)      rsp_ready[d] = 1'b0;
      else if (rmode[d] == 1) rsp_ready[d] = 1'b1;
      else                    rsp_ready[d] = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every cycle a response is held it must match the head.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (rsp_valid[d]) begin
          if (sb[d].size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            chk("rsp_r", rsp_r[d], sb[d][0].r);
            chk("rsp_ovf", rsp_ovf[d], sb[d][0].ovf);
            chk("rsp_m", rsp_m[d], sb[d][0].m);
            chk("op_count", opcnt(d), sb[d][0].opc);
            chk("ovf_count", ovcnt(d), sb[d][0].ovc);
            if (rsp_ready[d]) begin
              hs_cyc[d] = cyc;
              void'(sb[d].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    int acc, acc2;
    int accs[4];
    req_valid = '0; req_cin = '0;
    req_a = '0; req_b = '0; req_m = '0;
    rsp_ready = '0;
    cmax[0] = 256; cmax[1] = 4;
    mopc = '{0, 0}; movc = '{0, 0};
    rmode = '{1, 1};
    hs_cyc = '{0, 0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", rsp_valid[d], 0);
      chk("rst_r", rsp_r[d], 0);
      chk("rst_m", rsp_m[d], 0);
      chk("rst_ovf", rsp_ovf[d], 0);
      chk("rst_opc", opcnt(d), 0);
      chk("rst_ovc", ovcnt(d), 0);
    end
    rst = 1'b0;
    #1 chk("ready_after_rst", req_ready[0], 1);

    // Single shift-left op
    issue(0, 1, 0, 0, 8, acc);
    check_lat(0, 1);
    chk("shl_r", rsp_r[0], 2);
    chk("shl_m", rsp_m[0], 8);
    chk("shl_opc", opc0, 1);
    wait_idle(0);

    // Rotate right, then signed add overflow
    issue(0, 6, 0, 0, 15, acc);
    check_lat(0, 1);
    chk("ror_r", rsp_r[0], 3);
    wait_idle(0);
    issue(0, 8, 8, 0, 0, acc);
    check_lat(0, 1);
    chk("add_r", rsp_r[0], 0);
    chk("add_ovf", rsp_ovf[0], 1);
    chk("add_ovc", ovc0, 1);
    wait_idle(0);

    // Backpressure, then handshake coinciding with accept
    rmode[0] = 0;
    issue(0, 3, 5, 0, 0, acc);
    check_lat(0, 1);
    fork
      issue(0, 2, 1, 1, 1, acc2);
      begin
        repeat (5) begin
          @(posedge clk);
          #1 chk("bp_ready", req_ready[0], 0);
          chk("bp_valid", rsp_valid[0], 1);
        end
        rmode[0] = 1;
      end
    join
    chk("b2b_same_edge", acc2, hs_cyc[0]);
    check_lat(0, 1);
    wait_idle(0);

    // SETTLE=3 latency and back-to-back throughput
    issue(1, 5, 2, 0, 3, acc);
    check_lat(1, 3);
    wait_idle(1);
    for (int i = 0; i < 4; i++) issue(1, i + 1, 7, 1, 0, accs[i]);
    chk("b2b_span", accs[3] - accs[0], 12);
    wait_idle(1);
    chk("b2b_opc_wrap", opc1, 1);

    // Async reset while both are in WAIT
    fork
      issue(0, 7, 1, 0, 0, acc);
      issue(1, 7, 1, 0, 0, acc2);
    join
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_valid", rsp_valid[d], 0);
      chk("arst_opc", opcnt(d), 0);
      chk("arst_ovc", ovcnt(d), 0);
      sb[d].delete();
      mopc[d] = 0;
      movc[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 chk("no_rsp_after_rst", int'(rsp_valid), 0);
    end
    issue(0, 1, 0, 0, 8, acc);
    check_lat(0, 1);
    chk("post_rst_r", rsp_r[0], 2);
    chk("post_rst_opc", opc0, 1);
    wait_idle(0);

    // CNT_W=2 counters: five overflowing adds
    for (int i = 0; i < 5; i++) issue(1, 8, 8, 0, 0, acc);
    wait_idle(1);
    chk("sat_ovc", ovc1, 3);
    chk("wrap_opc", opc1, 1);

    // Random traffic with random backpressure
    rmode = '{2, 2};
    fork
      rstream(0, 40);
      rstream(1, 25);
    join
    rmode = '{1, 1};
    wait_idle(0);
    wait_idle(1);
    chk("sb0_empty", sb[0].size(), 0);
    chk("sb1_empty", sb[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=1 required=0");
    $fatal(1);
  end

endmodule
